// File: rtl/avalon_mm_arbiter2_if.sv
// One Avalon-MM link with active-low read_n/write_n and pipelined read return.
// The master modport drives the command; the slave modport answers it.
interface avalon_mm_arbiter2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int BE_W   = DATA_W / 8
);
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic              readdatavalid;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, read_n, write_n, address, byteenable, writedata,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  chipselect, read_n, write_n, address, byteenable, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/avalon_mm_arbiter2.sv
// Round-robin arbiter of two Avalon-MM requesters onto one downstream port.
// An owner-ID FIFO routes each pipelined read return back to the requester that issued it.
module avalon_mm_arbiter2 #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int BE_W        = DATA_W / 8,
    parameter int MAX_PENDING = 8,
    localparam int PW         = $clog2(MAX_PENDING),
    localparam int CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avalon_mm_arbiter2_if.slave   m0,
    avalon_mm_arbiter2_if.slave   m1,
    avalon_mm_arbiter2_if.master  s,
    output logic [CW-1:0]         pending_count,
    output logic                  rdv_err
);
    typedef enum logic [1:0] {G_NONE, G_0, G_1} grant_t;

    localparam logic [CW-1:0] MAXC = CW'(MAX_PENDING);

    grant_t                 grant_q, grant_d;
    logic                   last_q, last_d;
    logic [MAX_PENDING-1:0] own_q, own_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   rdv_err_q, rdv_err_d;

    logic              req0, req1, g_sel, g_req, g_rd, cmd_valid, accept, push, pop, owner;
    logic              cs_o, rd_n_o, wr_n_o;
    logic [ADDR_W-1:0] addr_o;
    logic [BE_W-1:0]   be_o;
    logic [DATA_W-1:0] wd_o;

    always_comb begin
        req0  = m0.chipselect & (~m0.read_n | ~m0.write_n);
        req1  = m1.chipselect & (~m1.read_n | ~m1.write_n);
        g_sel = (grant_q == G_1);
        g_req = (grant_q == G_0) ? req0 : (grant_q == G_1) ? req1 : 1'b0;
        g_rd  = g_sel ? ~m1.read_n : ~m0.read_n;
        // A read with the FIFO full is held off; a pop in the same cycle does not free it.
        cmd_valid = g_req & ~(g_rd & (count_q == MAXC));
        accept    = cmd_valid & ~s.waitrequest;

        cs_o   = 1'b0;
        rd_n_o = 1'b1;
        wr_n_o = 1'b1;
        addr_o = '0;
        be_o   = '0;
        wd_o   = '0;
        if (cmd_valid) begin
            cs_o   = 1'b1;
            rd_n_o = ~g_rd;
            wr_n_o = g_rd | (g_sel ? m1.write_n : m0.write_n);
            addr_o = g_sel ? m1.address    : m0.address;
            be_o   = g_sel ? m1.byteenable : m0.byteenable;
            wd_o   = g_sel ? m1.writedata  : m0.writedata;
        end
    end

    // Grant next state; the tie-break uses the pointer as updated by this cycle's accept.
    always_comb begin
        last_d  = last_q;
        grant_d = grant_q;
        if (accept) last_d = g_sel;
        if (grant_q == G_NONE || accept) begin
            if (req0 && req1) grant_d = last_d ? G_0 : G_1;
            else if (req0)    grant_d = G_0;
            else if (req1)    grant_d = G_1;
            else              grant_d = G_NONE;
        end else if (!g_req) begin
            grant_d = G_NONE;
        end
    end

    always_comb begin
        push      = accept & g_rd;
        pop       = s.readdatavalid & (count_q != '0);
        owner     = own_q[rd_ptr_q];
        own_d     = own_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            own_d[wr_ptr_q] = g_sel;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d   = count_q + CW'(push) - CW'(pop);
        rdv_err_d = rdv_err_q | (s.readdatavalid & (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q   <= G_NONE;
            last_q    <= 1'b1;
            own_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rdv_err_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            last_q    <= last_d;
            own_q     <= own_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rdv_err_q <= rdv_err_d;
        end
    end

    assign s.chipselect      = cs_o;
    assign s.read_n          = rd_n_o;
    assign s.write_n         = wr_n_o;
    assign s.address         = addr_o;
    assign s.byteenable      = be_o;
    assign s.writedata       = wd_o;
    assign m0.waitrequest    = ~(accept & ~g_sel);
    assign m1.waitrequest    = ~(accept & g_sel);
    assign m0.readdatavalid  = pop & ~owner;
    assign m1.readdatavalid  = pop & owner;
    assign m0.readdata       = s.readdata;
    assign m1.readdata       = s.readdata;
    assign pending_count     = count_q;
    assign rdv_err           = rdv_err_q;
endmodule

// File: tb/tb_avalon_mm_arbiter2.sv
// Directed bench for avalon_mm_arbiter2 (MAX_PENDING=4): single read, round robin,
// FIFO full blocking, write interleave, rdv_err and mid-operation reset.
module tb_avalon_mm_arbiter2;
    localparam int AW = 32, DW = 16, BW = 2, MP = 4, CW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CW-1:0] pending_count;
    logic rdv_err;
    int total = 0;
    int bad = 0;

    avalon_mm_arbiter2_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
    avalon_mm_arbiter2_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();
    avalon_mm_arbiter2_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) s_if ();

    avalon_mm_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if), .s(s_if),
        .pending_count(pending_count), .rdv_err(rdv_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here, checks happen at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.chipselect = 0; m0_if.read_n = 1; m0_if.write_n = 1;
        m0_if.address = '0; m0_if.byteenable = '0; m0_if.writedata = '0;
        m1_if.chipselect = 0; m1_if.read_n = 1; m1_if.write_n = 1;
        m1_if.address = '0; m1_if.byteenable = '0; m1_if.writedata = '0;
        s_if.waitrequest = 0; s_if.readdatavalid = 0; s_if.readdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        cyc();
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h55;
        reset_n = 0;
        cyc(); cyc();
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b0 || s_if.read_n !== 1'b1 || s_if.write_n !== 1'b1 ||
            s_if.address !== '0 || s_if.byteenable !== '0 || s_if.writedata !== '0) begin
            bad++; $display("FAIL reset_s_bus cs=%b rd_n=%b wr_n=%b addr=%h exp cs=0 rd_n=1 wr_n=1 addr=0",
                            s_if.chipselect, s_if.read_n, s_if.write_n, s_if.address);
        end
        total++;
        if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || pending_count !== 3'd0 || rdv_err !== 1'b0) begin
            bad++; $display("FAIL reset_state wr0=%b wr1=%b pend=%0d err=%b exp 1 1 0 0",
                            m0_if.waitrequest, m1_if.waitrequest, pending_count, rdv_err);
        end
        idle_inputs();
        reset_n = 1;
        cyc();
    endtask

    task automatic test_single_read();
        int lows = 0;
        do_reset();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h100; m0_if.byteenable = 2'b11;
        s_if.waitrequest = 1;
        @(negedge clk);
        if (m0_if.waitrequest === 1'b0) lows++;
        total++;
        if (s_if.chipselect !== 1'b0) begin
            bad++; $display("FAIL single_latency cs=%b exp 0", s_if.chipselect);
        end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            @(negedge clk);
            if (m0_if.waitrequest === 1'b0) lows++;
            total++;
            if (s_if.chipselect !== 1'b1 || s_if.read_n !== 1'b0 || s_if.address !== 32'h100 || pending_count !== 3'd0) begin
                bad++; $display("FAIL single_stall c=%0d cs=%b rd_n=%b addr=%h pend=%0d exp 1 0 100 0",
                                c, s_if.chipselect, s_if.read_n, s_if.address, pending_count);
            end
        end
        cyc();
        s_if.waitrequest = 0;
        @(negedge clk);
        if (m0_if.waitrequest === 1'b0) lows++;
        total++;
        if (s_if.address !== 32'h100 || m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin
            bad++; $display("FAIL single_accept addr=%h wr0=%b wr1=%b exp 100 0 1",
                            s_if.address, m0_if.waitrequest, m1_if.waitrequest);
        end
        cyc();
        m0_if.chipselect = 0; m0_if.read_n = 1;
        @(negedge clk);
        if (m0_if.waitrequest === 1'b0) lows++;
        total++;
        if (pending_count !== 3'd1 || s_if.chipselect !== 1'b0) begin
            bad++; $display("FAIL single_pend1 pend=%0d cs=%b exp 1 0", pending_count, s_if.chipselect);
        end
        cyc();
        s_if.readdatavalid = 1; s_if.readdata = 16'hBEEF;
        @(negedge clk);
        if (m0_if.waitrequest === 1'b0) lows++;
        total++;
        if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0 || m0_if.readdata !== 16'hBEEF) begin
            bad++; $display("FAIL single_return rdv0=%b rdv1=%b data=%h exp 1 0 beef",
                            m0_if.readdatavalid, m1_if.readdatavalid, m0_if.readdata);
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        if (m0_if.waitrequest === 1'b0) lows++;
        total++;
        if (pending_count !== 3'd0 || m0_if.readdatavalid !== 1'b0 || rdv_err !== 1'b0) begin
            bad++; $display("FAIL single_drain pend=%0d rdv0=%b err=%b exp 0 0 0",
                            pending_count, m0_if.readdatavalid, rdv_err);
        end
        total++;
        if (lows != 1) begin
            bad++; $display("FAIL single_wait_lows got=%0d exp 1", lows);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h10;
        m1_if.chipselect = 1; m1_if.read_n = 0; m1_if.address = 32'h20;
        cyc();
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b1 || s_if.address !== 32'h10 || m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin
            bad++; $display("FAIL rr_first cs=%b addr=%h wr0=%b wr1=%b exp 1 10 0 1",
                            s_if.chipselect, s_if.address, m0_if.waitrequest, m1_if.waitrequest);
        end
        cyc();
        m0_if.chipselect = 0; m0_if.read_n = 1;
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b1 || s_if.address !== 32'h20 || m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b1) begin
            bad++; $display("FAIL rr_second cs=%b addr=%h wr1=%b wr0=%b exp 1 20 0 1",
                            s_if.chipselect, s_if.address, m1_if.waitrequest, m0_if.waitrequest);
        end
        cyc();
        m1_if.chipselect = 0; m1_if.read_n = 1;
        s_if.readdatavalid = 1; s_if.readdata = 16'hAAAA;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd2 || m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0 || m0_if.readdata !== 16'hAAAA) begin
            bad++; $display("FAIL rr_ret0 pend=%0d rdv0=%b rdv1=%b data=%h exp 2 1 0 aaaa",
                            pending_count, m0_if.readdatavalid, m1_if.readdatavalid, m0_if.readdata);
        end
        cyc();
        s_if.readdata = 16'h5555;
        @(negedge clk);
        total++;
        if (m1_if.readdatavalid !== 1'b1 || m0_if.readdatavalid !== 1'b0 || m1_if.readdata !== 16'h5555) begin
            bad++; $display("FAIL rr_ret1 rdv1=%b rdv0=%b data=%h exp 1 0 5555",
                            m1_if.readdatavalid, m0_if.readdatavalid, m1_if.readdata);
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd0 || rdv_err !== 1'b0) begin
            bad++; $display("FAIL rr_drain pend=%0d err=%b exp 0 0", pending_count, rdv_err);
        end
    endtask

    task automatic test_max_pending();
        do_reset();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h200;
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (s_if.chipselect !== 1'b1 || s_if.address !== 32'h200 + i || m0_if.waitrequest !== 1'b0 || pending_count !== CW'(i)) begin
                bad++; $display("FAIL full_issue i=%0d cs=%b addr=%h wr0=%b pend=%0d exp 1 %h 0 %0d",
                                i, s_if.chipselect, s_if.address, m0_if.waitrequest, pending_count, 32'h200 + i, i);
            end
            cyc();
            m0_if.address = 32'h200 + i + 1;
        end
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b0 || m0_if.waitrequest !== 1'b1 || pending_count !== 3'd4) begin
            bad++; $display("FAIL full_block cs=%b wr0=%b pend=%0d exp 0 1 4",
                            s_if.chipselect, m0_if.waitrequest, pending_count);
        end
        cyc();
        s_if.readdatavalid = 1; s_if.readdata = 16'h0001;
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b0 || m0_if.waitrequest !== 1'b1 || m0_if.readdatavalid !== 1'b1) begin
            bad++; $display("FAIL full_pop_same_cycle cs=%b wr0=%b rdv0=%b exp 0 1 1",
                            s_if.chipselect, m0_if.waitrequest, m0_if.readdatavalid);
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        total++;
        if (s_if.chipselect !== 1'b1 || s_if.address !== 32'h204 || m0_if.waitrequest !== 1'b0 || pending_count !== 3'd3) begin
            bad++; $display("FAIL full_fifth cs=%b addr=%h wr0=%b pend=%0d exp 1 204 0 3",
                            s_if.chipselect, s_if.address, m0_if.waitrequest, pending_count);
        end
        cyc();
        m0_if.chipselect = 0; m0_if.read_n = 1;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd4) begin
            bad++; $display("FAIL full_peak pend=%0d exp 4", pending_count);
        end
        for (int j = 0; j < 4; j++) begin
            cyc();
            s_if.readdatavalid = 1;
            @(negedge clk);
            total++;
            if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin
                bad++; $display("FAIL full_drain j=%0d rdv0=%b rdv1=%b exp 1 0", j, m0_if.readdatavalid, m1_if.readdatavalid);
            end
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd0 || rdv_err !== 1'b0) begin
            bad++; $display("FAIL full_empty pend=%0d err=%b exp 0 0", pending_count, rdv_err);
        end
    endtask

    task automatic test_write_mix();
        bit seen = 0;
        do_reset();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h300;
        cyc();
        cyc();
        m0_if.chipselect = 0; m0_if.read_n = 1;
        m1_if.chipselect = 1; m1_if.write_n = 0; m1_if.address = 32'h40;
        m1_if.writedata = 16'h1234; m1_if.byteenable = 2'b11;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (m1_if.waitrequest === 1'b0) begin
                seen = 1;
                total++;
                if (s_if.chipselect !== 1'b1 || s_if.write_n !== 1'b0 || s_if.read_n !== 1'b1 ||
                    s_if.address !== 32'h40 || s_if.writedata !== 16'h1234 || s_if.byteenable !== 2'b11 || pending_count !== 3'd1) begin
                    bad++; $display("FAIL wr_issue cs=%b wr_n=%b rd_n=%b addr=%h wd=%h be=%b pend=%0d exp 1 0 1 40 1234 11 1",
                                    s_if.chipselect, s_if.write_n, s_if.read_n, s_if.address, s_if.writedata, s_if.byteenable, pending_count);
                end
            end else cyc();
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL wr_timeout m1 write never accepted within 6 cycles");
        end
        cyc();
        m1_if.chipselect = 0; m1_if.write_n = 1;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd1) begin
            bad++; $display("FAIL wr_pend pend=%0d exp 1", pending_count);
        end
        cyc();
        s_if.readdatavalid = 1; s_if.readdata = 16'h7777;
        @(negedge clk);
        total++;
        if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL wr_ret rdv0=%b rdv1=%b exp 1 0", m0_if.readdatavalid, m1_if.readdatavalid);
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd0) begin
            bad++; $display("FAIL wr_drain pend=%0d exp 0", pending_count);
        end
    endtask

    task automatic test_rdv_err();
        do_reset();
        s_if.readdatavalid = 1; s_if.readdata = 16'hDEAD;
        @(negedge clk);
        total++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0 || rdv_err !== 1'b0) begin
            bad++; $display("FAIL err_no_steer rdv0=%b rdv1=%b err=%b exp 0 0 0",
                            m0_if.readdatavalid, m1_if.readdatavalid, rdv_err);
        end
        cyc();
        s_if.readdatavalid = 0;
        cyc(); cyc();
        @(negedge clk);
        total++;
        if (rdv_err !== 1'b1 || pending_count !== 3'd0) begin
            bad++; $display("FAIL err_sticky err=%b pend=%0d exp 1 0", rdv_err, pending_count);
        end
        reset_n = 0;
        cyc();
        reset_n = 1;
        @(negedge clk);
        total++;
        if (rdv_err !== 1'b0) begin
            bad++; $display("FAIL err_clear err=%b exp 0", rdv_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_if.chipselect = 1; m0_if.read_n = 0; m0_if.address = 32'h10;
        m1_if.chipselect = 1; m1_if.read_n = 0; m1_if.address = 32'h20;
        cyc();
        cyc();
        m0_if.chipselect = 0; m0_if.read_n = 1;
        cyc();
        @(negedge clk);
        total++;
        if (pending_count !== 3'd2) begin
            bad++; $display("FAIL mid_pend2 pend=%0d exp 2", pending_count);
        end
        // m1 keeps requesting through reset; grant must still come back as NONE.
        reset_n = 0;
        cyc();
        reset_n = 1;
        @(negedge clk);
        total++;
        if (pending_count !== 3'd0 || s_if.chipselect !== 1'b0 || m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
            bad++; $display("FAIL mid_cleared pend=%0d cs=%b wr0=%b wr1=%b exp 0 0 1 1",
                            pending_count, s_if.chipselect, m0_if.waitrequest, m1_if.waitrequest);
        end
        m1_if.chipselect = 0; m1_if.read_n = 1;
        cyc();
        s_if.readdatavalid = 1;
        @(negedge clk);
        total++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL mid_stale_steer rdv0=%b rdv1=%b exp 0 0", m0_if.readdatavalid, m1_if.readdatavalid);
        end
        cyc();
        s_if.readdatavalid = 0;
        @(negedge clk);
        total++;
        if (rdv_err !== 1'b1) begin
            bad++; $display("FAIL mid_stale_err err=%b exp 1", rdv_err);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_max_pending();
        test_write_mix();
        test_rdv_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avalon_mm_arbiter2.md
Name: avalon_mm_arbiter2

Overview:
- Two-requester Avalon-MM arbiter sharing one SDRAM/bridge master port, e.g. the sobel engine and the NN accelerator front end.
- Each requester sees a standard active-low read_n/write_n Avalon-MM slave interface.
- Grants are round-robin; grant is held through slave waitrequest.
- Outstanding pipelined reads are tracked in an owner-ID FIFO so each returned readdatavalid goes to the master that issued the read.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 16, data width.
- BE_W, DATA_W/8, byteenable width.
- MAX_PENDING, 8, maximum outstanding reads (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- mX_chipselect  in  1  requester X select (X = 0, 1; the mX_ group repeats per requester)
- mX_read_n  in  1  active-low read
- mX_write_n  in  1  active-low write
- mX_address  in  ADDR_W  address
- mX_byteenable  in  BE_W  byte enables
- mX_writedata  in  DATA_W  write data
- mX_waitrequest  out  1  stall to requester X
- mX_readdatavalid  out  1  read data valid to requester X
- mX_readdata  out  DATA_W  read data to requester X
- s_chipselect, s_read_n, s_write_n, s_address, s_byteenable, s_writedata  out  —  shared downstream command, same widths as mX_
- s_waitrequest  in  1  downstream stall
- s_readdatavalid  in  1  downstream read data valid
- s_readdata  in  DATA_W  downstream read data
- pending_count  out  log2(MAX_PENDING)+1  outstanding reads
- rdv_err  out  1  sticky: readdatavalid received with no pending read

Behaviour:
- One clock; reset is synchronous and active-low. All state updates on the rising edge of clk; reset_n=0 sampled at an edge clears all state.
- Request: reqX = mX_chipselect & (~mX_read_n | ~mX_write_n). Read has priority if both read_n and write_n are low (illegal; documented only).
- State: grant register {NONE, G0, G1} and last_served pointer. Reset: grant=NONE, last_served=1 (m0 wins the first tie), FIFO empty, rdv_err=0.
- Arbitration runs when grant=NONE or the current command is accepted this cycle:
  - Only one requester active: that requester wins.
  - Both active: the requester ≠ last_served wins.
  - Neither active: grant=NONE.
  - The new grant is registered, so the command reaches s_* one cycle after the request is first seen (1-cycle arbitration latency). Back-to-back grants occur with no idle cycle.
- s_* is a combinational mux of the granted requester's inputs.
  - grant=NONE: s_chipselect=0, s_read_n=1, s_write_n=1, s_address/s_byteenable/s_writedata=0. These are also the reset values.
  - Granted read with pending_count==MAX_PENDING: drive as NONE (command blocked). Same-cycle pop is not considered.
- Accept: cmd_valid & ~s_waitrequest. On accept, last_served is updated to the granted ID. A read pushes the granted ID into the owner FIFO; a write pushes nothing.
- mX_waitrequest=0 only in the cycle requester X's command is accepted; 1 otherwise, including in reset and while not granted.
- Grant is never revoked before accept. If the granted requester drops its request before accept (protocol violation), grant returns to NONE next cycle.
- Read return:
  - s_readdatavalid with FIFO non-empty: the FIFO head is popped, and the owner's mX_readdatavalid=1 in the same cycle (combinational).
  - mX_readdata = s_readdata to both requesters at all times; only the readdatavalid is steered.
  - The non-owner's readdatavalid stays 0.
- Simultaneous push and pop: both take effect; pending_count is unchanged.
- s_readdatavalid with FIFO empty: no mX_readdatavalid, rdv_err set to 1 and held until reset.
- pending_count = FIFO occupancy, 0..MAX_PENDING; it never wraps.
- Reset mid-operation: grant, FIFO and pointers cleared at that edge. Read data arriving afterwards for pre-reset reads raises rdv_err.

Test Plan:
- m0 read addr 0x100, s_waitrequest high 3 cycles, s_readdatavalid 2 cycles later with 0xBEEF -> s_address=0x100 from cycle 1, m0_waitrequest low exactly once, m0_readdatavalid=1 with 0xBEEF, m1_readdatavalid=0, pending_count 0→1→0.
- After reset, m0 and m1 both read in the same cycle (0x10, 0x20), s_waitrequest=0 -> 0x10 issued then 0x20 on consecutive cycles; returns 0xAAAA then 0x5555 steered to m0 then m1.
- MAX_PENDING=4, m0 issues 5 reads, no readdatavalid -> 5th holds m0_waitrequest=1 and s_chipselect=0. After one s_readdatavalid, the 5th issues next cycle; pending_count peaks at 4.
- m0 read pending, m1 writes 0x1234 to 0x40 -> write issues, pending_count unchanged, next readdatavalid still goes to m0.
- s_readdatavalid with pending_count=0 -> rdv_err=1 and stays 1, no mX_readdatavalid; reset_n low one cycle -> rdv_err=0.
- 2 reads outstanding, reset_n low one edge -> next cycle pending_count=0, grant NONE, both waitrequests 1, s_chipselect=0.
